data_ram_responder: RTL and testbench

- Data-memory responder on the load/store port driven by the CPU memory-access stage.
- Accepts one request at a time: address, write enable, byte selects, store data.
- Performs a byte-masked write or a full-word read after a programmable number of wait states.
- Raises a stall request to the pipeline until each access completes.
- Big-endian byte lanes; word-organised synchronous RAM array.

---
 rtl/data_ram_responder.sv | 132 +++++++++++++
 tb/tb_data_ram_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// Data-memory responder for the CPU load/store port: one request at a time, byte-masked
// stores and full-word loads completing after WAIT_CYCLES wait states.
module data_ram_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        stall_req_o
);

    localparam logic [3:0] WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_q, data_d;

    logic [31:0]         mem_q [2**ADDR_W];

    // Access actually performed on the DONE-entry edge; with zero wait states that edge is
    // also the request edge, so the live inputs are used instead of the latched copy.
    logic                enter_done;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_sel;
    logic [31:0]         acc_wdata;

    logic                unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        wdata_d    = wdata_q;
        enter_done = 1'b0;
        acc_we     = we_q;
        acc_idx    = idx_q;
        acc_sel    = sel_q;
        acc_wdata  = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (ce_i) begin
                    we_d    = we_i;
                    idx_d   = addr_i[ADDR_W+1:2];
                    sel_d   = sel_i;
                    wdata_d = data_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                        acc_we     = we_i;
                        acc_idx    = addr_i[ADDR_W+1:2];
                        acc_sel    = sel_i;
                        acc_wdata  = data_i;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d = 32'd0;
        if (enter_done && !acc_we) begin
            data_d = mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // RAM is not reset, but a reset on the DONE-entry edge must suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_done && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_o      = data_q;
    assign ready_o     = (state_q == StDone);
    assign stall_req_o = (ce_i && (state_q != StDone)) || (state_q == StWait);

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed + randomized bench for data_ram_responder; two instances cover WAIT_CYCLES=2 and 0.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_a = 1'b0, ce_b = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] dout_a, dout_b;
    logic        ready_a, ready_b, stall_a, stall_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [2][1024];
    bit          known [2][1024];

    always #5 clk = ~clk;

    data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .ce_i(ce_a), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(dout_a), .ready_o(ready_a), .stall_req_o(stall_a)
    );

    data_ram_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .ce_i(ce_b), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .data_o(dout_b), .ready_o(ready_b), .stall_req_o(stall_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input int i);
        return (i != 0) ? ready_b : ready_a;
    endfunction

    function automatic logic stall_of(input int i);
        return (i != 0) ? stall_b : stall_a;
    endfunction

    function automatic logic [31:0] dout_of(input int i);
        return (i != 0) ? dout_b : dout_a;
    endfunction

    function automatic int unsigned word_of(input logic [31:0] a);
        return (a / 4) % 1024;
    endfunction

    task automatic set_ce(input int i, input logic v);
        if (i != 0) ce_b = v;
        else ce_a = v;
    endtask

    task automatic model_store(input int i, input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        model[i][word_of(a)] = (model[i][word_of(a)] & ~m) | (d & m);
        if (s == 4'hF) known[i][word_of(a)] = 1'b1;
    endtask

    // One complete access with ce held until ready, then one idle cycle checked.
    task automatic access(input int i, input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d);
        int lat;
        bit got;
        logic [31:0] rd;
        lat = (i != 0) ? 1 : 3;
        got = 1'b0;
        rd  = 32'd0;
        @(negedge clk);
        we = w; addr = a; sel = s; wdata = d;
        set_ce(i, 1'b1);
        #1 chk("stall_c0", stall_of(i), 1);
        for (int c = 1; c <= lat + 20 && !got; c++) begin
            @(negedge clk);
            chk("ready_lat", rdy_of(i), (c == lat));
            chk("stall", stall_of(i), (c != lat));
            if (rdy_of(i)) begin
                got = 1'b1;
                rd  = dout_of(i);
                set_ce(i, 1'b0);
            end
        end
        chk("ready_seen", got, 1);
        if (w) begin
            chk("store_dout", rd, 32'd0);
            model_store(i, a, s, d);
        end else if (known[i][word_of(a)]) begin
            chk("load_data", rd, model[i][word_of(a)]);
        end
        @(negedge clk);
        chk("idle_ready", rdy_of(i), 0);
        chk("idle_dout", dout_of(i), 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        int          inst;
        bit          got;

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 1024; j++) begin
                model[i][j] = 32'd0;
                known[i][j] = 1'b0;
            end

        // Reset held 3 cycles with a request pending.
        ce_a = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ready", ready_a, 0);
            chk("rst_dout", dout_a, 32'd0);
            chk("rst_ready_b", ready_b, 0);
        end
        rst = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            chk("post_rst_lat", ready_a, (c == 3));
            if (ready_a) got = 1'b1;
        end
        chk("post_rst_seen", got, 1);
        ce_a = 1'b0;
        @(negedge clk);

        // Full-word store/load and byte-lane masking.
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        access(0, 1'b0, 32'h10, 4'h0, 32'h0);
        chk("model_deadbeef", model[0][4], 32'hDEADBEEF);
        access(0, 1'b1, 32'h10, 4'b0100, 32'h11223344);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        chk("model_de22beef", model[0][4], 32'hDE22BEEF);
        access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
        access(0, 1'b0, 32'h10, 4'h0, 32'h0);

        // Zero wait states, then ce held high for back-to-back loads.
        access(1, 1'b1, 32'h20, 4'hF, 32'h5);
        access(1, 1'b0, 32'h20, 4'h0, 32'h0);
        @(negedge clk);
        we = 1'b0; addr = 32'h20; ce_b = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("b2b_ready", ready_b, (c % 2 == 1));
            chk("b2b_dout", dout_b, (c % 2 == 1) ? 32'h5 : 32'h0);
            chk("b2b_stall", stall_b, (c % 2 == 0));
        end
        ce_b = 1'b0;
        @(negedge clk);

        // ce dropped during WAIT: latched store must still complete.
        @(negedge clk);
        we = 1'b1; addr = 32'h40; sel = 4'hF; wdata = 32'hCAFEF00D; ce_a = 1'b1;
        @(negedge clk);
        chk("drop_c1_ready", ready_a, 0);
        ce_a = 1'b0; we = 1'b0; addr = 32'h44; wdata = $urandom;
        @(negedge clk);
        chk("drop_c2_stall", stall_a, 1);
        chk("drop_c2_ready", ready_a, 0);
        @(negedge clk);
        chk("drop_c3_ready", ready_a, 1);
        model_store(0, 32'h40, 4'hF, 32'hCAFEF00D);
        access(0, 1'b0, 32'h40, 4'h0, 32'h0);

        // Reset on the DONE-entry edge cancels the store and the ready pulse.
        access(0, 1'b1, 32'h80, 4'hF, 32'h0);
        @(negedge clk);
        we = 1'b1; addr = 32'h80; sel = 4'hF; wdata = 32'h12345678; ce_a = 1'b1;
        @(negedge clk);
        chk("rstmid_c1_ready", ready_a, 0);
        @(negedge clk);
        chk("rstmid_c2_ready", ready_a, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_c3_ready", ready_a, 0);
        chk("rstmid_c3_dout", dout_a, 32'd0);
        rst = 1'b0; ce_a = 1'b0;
        @(negedge clk);
        chk("rstmid_c4_ready", ready_a, 0);
        access(0, 1'b0, 32'h80, 4'h0, 32'h0);
        access(0, 1'b0, 32'h1080, 4'h0, 32'h0);
        access(0, 1'b1, 32'h10C3, 4'hF, 32'hA5A55A5A);
        access(0, 1'b0, 32'hC0, 4'h0, 32'h0);

        // Randomized traffic over a small aliased window on both instances.
        for (int k = 0; k < 16; k++) begin
            access(0, 1'b1, 32'h200 + 32'(4 * k), 4'hF, $urandom);
            access(1, 1'b1, 32'h200 + 32'(4 * k), 4'hF, $urandom);
        end
        for (int n = 0; n < 60; n++) begin
            inst = int'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_F003) | (32'h200 + 32'(4 * $urandom_range(0, 15)));
            d = $urandom;
            access(inst, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
